// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver with mid-bit sampling.
// The RxD input passes through a two-flop synchronizer. A single bit timer
// and a 3-bit bit index drive a five-state FSM. Each correctly framed byte
// is offered to the consumer through a level rx_valid flag and an rx_ack
// acknowledge.
//
// Handshake: rx_valid is a level signal. It rises when a byte is delivered
// and stays high until the consumer pulses rx_ack. If rx_ack arrives while
// rx_valid is high, rx_valid clears on the next cycle, unless a new byte
// lands on that same cycle. In that case the new byte replaces the old one
// and rx_valid stays high. If a byte lands while rx_valid is high and
// rx_ack is low, the new byte is dropped and overrun pulses. When rx_valid
// is low, rx_ack has no effect.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RxD,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_HALF = TW'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    state_t        state, state_nx;
    logic          rx_m, rx_s;
    logic [TW-1:0] timer, timer_nx;
    logic [2:0]    bit_idx, bit_idx_nx;
    logic [7:0]    shreg, shreg_nx;
    logic          good_stop, bad_stop;

    // Two-flop synchronizer; the idle level is high so both flops reset to 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= RxD;
            rx_s <= rx_m;
        end
    end

    // FSM, bit timer, bit index and shift register state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_nx;
            timer   <= timer_nx;
            bit_idx <= bit_idx_nx;
            shreg   <= shreg_nx;
        end
    end

    // Next-state logic. The line is sampled at the start-bit middle and then
    // once per bit period, so that every later sample falls mid-bit.
    always_comb begin
        state_nx   = state;
        timer_nx   = timer + TW'(1);
        bit_idx_nx = bit_idx;
        shreg_nx   = shreg;
        good_stop  = 1'b0;
        bad_stop   = 1'b0;
        case (state)
            IDLE: begin
                timer_nx = '0;
                if (!rx_s) state_nx = START;
            end
            START: begin
                if (timer == T_HALF) begin
                    timer_nx   = '0;
                    bit_idx_nx = '0;
                    // A line that is high again at the start-bit middle was a glitch.
                    state_nx   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (timer == T_LAST) begin
                    timer_nx   = '0;
                    shreg_nx   = {rx_s, shreg[7:1]};
                    bit_idx_nx = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_nx = STOP;
                end
            end
            STOP: begin
                if (timer == T_LAST) begin
                    timer_nx = '0;
                    // Re-arm at the stop-bit middle so that back-to-back frames are caught.
                    if (rx_s) begin
                        good_stop = 1'b1;
                        state_nx  = IDLE;
                    end else begin
                        bad_stop  = 1'b1;
                        state_nx  = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                // A break or stuck-low line must not be taken for a new start bit.
                timer_nx = '0;
                if (rx_s) state_nx = IDLE;
            end
            default: begin
                timer_nx = '0;
                state_nx = IDLE;
            end
        endcase
    end

    // Delivery, overrun and frame-error outputs. A framing error leaves the
    // held byte untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= bad_stop;
            overrun   <= 1'b0;
            if (good_stop) begin
                if (rx_valid && !rx_ack) begin
                    overrun <= 1'b1;
                end else begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                end
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
